// File: rtl/common.sv
// Shared types for the iterative divider: FSM state encoding and the captured
// operation mode.
package common;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  typedef struct packed {
    logic is_signed;
    logic is_word;
    logic want_rem;
  } div_mode_t;

endpackage

// File: rtl/div_unit_param_if.sv
// Request/response bundle between the execute-stage requester (master) and the
// divider (slave).
interface div_unit_param_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             flush;
  logic             is_signed;
  logic             is_word;
  logic             want_rem;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c;

  modport master (
    output valid, flush, is_signed, is_word, want_rem, a, b,
    input  busy, done, c
  );

  modport slave (
    input  valid, flush, is_signed, is_word, want_rem, a, b,
    output busy, done, c
  );
endinterface

// File: rtl/div_restoring_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module div_restoring_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, dvd_i[WIDTH-1]};
  // Partial remainder stays below the divisor, so bit WIDTH of diff is the borrow.
  assign diff    = shifted - {1'b0, div_i};
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o   = {dvd_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit_param.sv
// Iterative signed/unsigned, full/word divider with sign pre/post correction.
// Optional early completion for special operands when DIV_FASTPATH_EN is defined.
module div_unit_param
  import common::*;
#(
  parameter int WIDTH = 64
) (
  input logic             clk,
  input logic             reset,
  div_unit_param_if.slave dif
);

  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  div_mode_t        mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic [WIDTH-1:0] a_ext, b_ext, mag_a, mag_b;
  logic [WIDTH-1:0] step_rem, step_quo, q_fix, r_fix, spec_q, spec_r;
  logic             sa, sb, dz, ovf;

  function automatic logic [WIDTH-1:0] pick(input div_mode_t m,
                                            input logic [WIDTH-1:0] q,
                                            input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] v;
    v = m.want_rem ? r : q;
    return m.is_word ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction

  assign a_ext = mode_q.is_word ? {{HW{mode_q.is_signed & a_q[HW-1]}}, a_q[HW-1:0]} : a_q;
  assign b_ext = mode_q.is_word ? {{HW{mode_q.is_signed & b_q[HW-1]}}, b_q[HW-1:0]} : b_q;
  assign sa    = mode_q.is_signed & a_ext[WIDTH-1];
  assign sb    = mode_q.is_signed & b_ext[WIDTH-1];
  assign mag_a = sa ? -a_ext : a_ext;
  assign mag_b = sb ? -b_ext : b_ext;

  assign dz  = (b_ext == '0);
  assign ovf = mode_q.is_signed & (&b_ext) &
               (mode_q.is_word ? (a_q[HW-1] & ~(|a_q[HW-2:0]))
                               : (a_q[WIDTH-1] & ~(|a_q[WIDTH-2:0])));

  // Divide-by-zero and overflow results; also the |a| < |b| fast result.
  assign spec_q = dz ? {WIDTH{1'b1}} : (ovf ? a_ext : '0);
  assign spec_r = ovf ? '0 : a_ext;

  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (dif.valid && !dif.flush) begin
          a_d              = dif.a;
          b_d              = dif.b;
          mode_d.is_signed = dif.is_signed;
          mode_d.is_word   = dif.is_word;
          mode_d.want_rem  = dif.want_rem;
          state_d          = PREP;
        end
      end
      PREP: begin
        // Word dividends are left-aligned so N shifts consume exactly their bits.
        quo_d   = mode_q.is_word ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
        rem_d   = '0;
        div_d   = mag_b;
        cnt_d   = mode_q.is_word ? CW'(HW) : CW'(WIDTH);
        negq_d  = sa ^ sb;
        negr_d  = sa;
        state_d = ITER;
`ifdef DIV_FASTPATH_EN
        if (dz || ovf || (mag_a < mag_b)) begin
          c_d     = pick(mode_q, spec_q, spec_r);
          state_d = DONE;
        end
`endif
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        c_d     = (dz || ovf) ? pick(mode_q, spec_q, spec_r) : pick(mode_q, q_fix, r_fix);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.flush) begin
      state_d = IDLE;
      c_d     = c_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      c_q     <= c_d;
    end
  end

  assign dif.busy = (state_q != IDLE);
  assign dif.done = (state_q == DONE);
  assign dif.c    = c_q;

endmodule

// File: tb/tb_div_unit_param.sv
// Randomized self-checking bench for div_unit_param against an arithmetic
// reference model, plus directed literal checks.
module tb_div_unit_param;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  // Reference-model state for the op in flight.
  bit          active;
  int          start;
  int          lat;
  logic [63:0] exp_c;
  logic [63:0] last_c;

  div_unit_param_if #(.WIDTH(64)) dif();

  div_unit_param #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, want);
    end
  endtask

  function automatic logic [63:0] ext_in(input logic [63:0] x, input logic sg, input logic wd);
    if (!wd) return x;
    return sg ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] x, input logic sg);
    return (sg && x[63]) ? -x : x;
  endfunction

  // Result per RISC-V M rules, plus latency in cycles from the sampling cycle to done.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sg,
                       input logic wd, input logic rm,
                       output logic [63:0] res, output int el);
    logic [63:0] ax, bx, q, r;
    bit special;
    ax = ext_in(a, sg, wd);
    bx = ext_in(b, sg, wd);
    special = 1'b0;
    if (bx == 64'd0) begin
      q = '1; r = ax; special = 1'b1;
    end else if (sg && bx == '1 &&
                 ax == (wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = ax; r = 64'd0; special = 1'b1;
    end else if (sg) begin
      q = $signed(ax) / $signed(bx);
      r = $signed(ax) % $signed(bx);
    end else begin
      q = ax / bx;
      r = ax % bx;
    end
    if (mag(ax, sg) < mag(bx, sg)) special = 1'b1;
    res = rm ? r : q;
    if (wd) res = {{32{res[31]}}, res[31:0]};
`ifdef DIV_FASTPATH_EN
    el = special ? 2 : (wd ? 35 : 67);
`else
    el = special ? (wd ? 35 : 67) : (wd ? 35 : 67);
`endif
  endtask

  // Compare process: DUT outputs against the model on every cycle out of reset.
  always @(negedge clk) begin : cmp
    int k;
    logic eb, ed;
    logic [63:0] ec;
    if (!reset) begin
      k  = cyc - start;
      eb = 1'b0;
      ed = 1'b0;
      ec = last_c;
      if (active) begin
        eb = (k >= 1) && (k <= lat);
        ed = (k == lat);
        ec = (k >= lat) ? exp_c : last_c;
      end
      chk("busy", {63'b0, dif.busy}, {63'b0, eb});
      chk("done", {63'b0, dif.done}, {63'b0, ed});
      chk("c", dif.c, ec);
    end
  end

  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sg, input logic wd, input logic rm);
    logic [63:0] er;
    int el;
    model(a, b, sg, wd, rm, er, el);
    @(negedge clk); #1;
    dif.a = a; dif.b = b;
    dif.is_signed = sg; dif.is_word = wd; dif.want_rem = rm;
    dif.valid = 1'b1;
    start = cyc; lat = el; exp_c = er; active = 1'b1;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic sg, input logic wd, input logic rm, input bit noisy,
                        output logic [63:0] c_got, output int done_k);
    int k;
    start_op(a, b, sg, wd, rm);
    done_k = -1;
    c_got  = 'x;
    do begin
      @(negedge clk); #1;
      k = cyc - start;
      if (dif.done && done_k < 0) begin
        done_k = k;
        c_got  = dif.c;
      end
      if (noisy) begin
        dif.a = {$urandom, $urandom};
        dif.b = {$urandom, $urandom};
        dif.is_signed = 1'($urandom);
        if (k >= 2 && $urandom_range(0, 3) == 0) dif.valid = 1'b0;
      end
      if (k == lat) begin
        dif.valid = 1'b0;
        active    = 1'b0;
        last_c    = exp_c;
      end
    end while (k < lat);
  endtask

  initial begin : watchdog
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] cg;
    int dk;
    int exp_fast_full, exp_fast_word;
`ifdef DIV_FASTPATH_EN
    exp_fast_full = 2; exp_fast_word = 2;
`else
    exp_fast_full = 67; exp_fast_word = 35;
`endif
    total = 0; bad = 0; cyc = 0;
    active = 1'b0; start = 0; lat = 0; exp_c = '0; last_c = '0;
    reset = 1'b1;
    dif.valid = 1'b0; dif.flush = 1'b0;
    dif.is_signed = 1'b0; dif.is_word = 1'b0; dif.want_rem = 1'b0;
    dif.a = '0; dif.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, dif.busy}, 64'd0);
    chk("rst_done", {63'b0, dif.done}, 64'd0);
    chk("rst_c", dif.c, 64'd0);
    #1 reset = 1'b0;

    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0, cg, dk);
    chk("u_quo", cg, 64'd14);
    chk("u_quo_lat", 64'(dk), 64'd67);
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 1'b0, cg, dk);
    chk("u_rem", cg, 64'd2);
    run_op(-64'sd100, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0, cg, dk);
    chk("s_neg_quo", cg, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op(-64'sd100, 64'd7, 1'b1, 1'b0, 1'b1, 1'b0, cg, dk);
    chk("s_neg_rem", cg, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'd100, -64'sd7, 1'b1, 1'b0, 1'b0, 1'b0, cg, dk);
    chk("s_div_neg_quo", cg, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op(64'd100, -64'sd7, 1'b1, 1'b0, 1'b1, 1'b0, cg, dk);
    chk("s_div_neg_rem", cg, 64'd2);
    run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, cg, dk);
    chk("w_ovf_quo", cg, 64'hFFFF_FFFF_8000_0000);
    chk("w_ovf_lat", 64'(dk), 64'(exp_fast_word));
    run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, cg, dk);
    chk("w_ovf_rem", cg, 64'd0);
    run_op(64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, cg, dk);
    chk("w_dz_quo", cg, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'd5, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, cg, dk);
    chk("w_dz_rem", cg, 64'd5);
    run_op(64'd3, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0, cg, dk);
    chk("small_quo", cg, 64'd0);
    chk("small_lat", 64'(dk), 64'(exp_fast_full));

    // Flush in cycle 10 of an operation.
    start_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
    do begin @(negedge clk); #1; end while (cyc - start < 10);
    dif.flush = 1'b1; dif.valid = 1'b0; active = 1'b0;
    @(negedge clk); #1;
    chk("flush_busy", {63'b0, dif.busy}, 64'd0);
    chk("flush_done", {63'b0, dif.done}, 64'd0);
    dif.flush = 1'b0;
    run_op(64'd81, 64'd9, 1'b0, 1'b0, 1'b0, 1'b0, cg, dk);
    chk("after_flush_quo", cg, 64'd9);
    chk("after_flush_lat", 64'(dk), 64'd67);

    // Reset in the middle of the iteration phase.
    start_op(64'd12345, 64'd17, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    dif.valid = 1'b0; active = 1'b0; last_c = '0;
    #1;
    chk("midrst_busy", {63'b0, dif.busy}, 64'd0);
    chk("midrst_done", {63'b0, dif.done}, 64'd0);
    chk("midrst_c", dif.c, 64'd0);
    @(negedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      logic sg, wd, rm;
      sg = 1'($urandom); wd = 1'($urandom); rm = 1'($urandom);
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 63);
      case ($urandom_range(0, 6))
        0: rb = 64'd0;
        1: rb = 64'($urandom_range(1, 20));
        2: rb = '1;
        3: rb = {$urandom, $urandom};
        4: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
        5: begin
          ra = wd ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
          rb = '1;
        end
        default: rb = ra >> $urandom_range(0, 8);
      endcase
      run_op(ra, rb, sg, wd, rm, 1'b1, cg, dk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
